int_to_float: RTL and testbench

Sequential signed-integer to floating-point converter that sits directly upstream of the `float` holding register. It accepts one two's-complement integer per transaction over a valid/ready handshake and normalises it with a one-bit-per-cycle shifter. It rounds the result, packs it into `float_pkg::float_t`, and emits a one-cycle `wen_o`/`wdata_o` pulse that drives the register's `wen_i`/`wdata_i`.

---
 rtl/int_to_float.sv | 180 ++++++++++++++++++
 tb/tb_int_to_float.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/int_to_float.sv
// Signed integer to float converter feeding the float holding register.
// Latency: 2 + leading-zero count of |int_i| cycles (2 for zero), range 2..IntWidth+1.
// Backpressure: ready_o is high only in IDLE; no result-side stall (wen_o is a strobe).
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid_i, int_i      conversion request and signed two's-complement operand
//   ready_o             request accepted on a rising edge when valid_i & ready_o
//   wen_o, wdata_o      one-cycle result strobe and packed float_pkg::float_t result
//   inexact_o           qualified by wen_o: nonzero bits were discarded
//
// Build option: INT_TO_FLOAT_ROUND_NEAREST_EN selects round-to-nearest-even;
// when undefined the result is truncated toward zero.

package float_pkg;
  localparam int MantissaWidth       = 23;
  localparam int BiasedExponentWidth = 8;

  typedef struct packed {
    logic                           sign;
    logic [BiasedExponentWidth-1:0] exponent;
    logic [MantissaWidth-1:0]       mantissa;
  } float_t;
endpackage

module int_to_float
  import float_pkg::*;
#(
  parameter int IntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [IntWidth-1:0] int_i,
  output logic                ready_o,
  output logic                wen_o,
  output float_t              wdata_o,
  output logic                inexact_o
);

  localparam int MW   = MantissaWidth;
  localparam int EW   = BiasedExponentWidth;
  localparam int Bias = (1 << (EW - 1)) - 1;
  // Magnitude below its leading one, padded so guard and sticky always exist.
  localparam int ExtW = IntWidth - 1 + MW + 2;

  localparam logic [EW-1:0]       ExpInit = EW'(Bias + IntWidth - 1);
  localparam logic [EW-1:0]       ExpOne  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [IntWidth-1:0] IntOne  = {{(IntWidth-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IntWidth-1:0] mag_q, mag_d;
  logic [EW-1:0]       exp_q, exp_d;
  logic                sign_q, sign_d;
  logic                zero_q, zero_d;
  logic                wen_q, wen_d;
  float_t              wdata_q, wdata_d;
  logic                inexact_q, inexact_d;

  logic [ExtW-1:0]     ext;
  logic [MW-1:0]       mant_raw;
  logic                guard;
  logic                sticky;
  logic                round_up;
  logic [MW:0]         mant_sum;
  logic [EW-1:0]       exp_rnd;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (valid_i) state_d = NORM;
      NORM: if ((mag_q == '0) || mag_q[IntWidth-1]) state_d = PACK;
      PACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state; nothing reaches ready_o from valid_i.
  always_comb begin
    ready_o   = (state_q == IDLE);
    wen_o     = wen_q;
    wdata_o   = wdata_q;
    inexact_o = inexact_q;
  end

  // Rounding datapath, only meaningful in PACK once the leading one sits at the MSB.
  always_comb begin
    ext      = {mag_q[IntWidth-2:0], {(MW+2){1'b0}}};
    mant_raw = ext[ExtW-1 -: MW];
    guard    = ext[ExtW-1-MW];
    sticky   = |ext[ExtW-2-MW:0];
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
    round_up = guard & (sticky | mant_raw[0]);
`else
    round_up = 1'b0;
`endif
    mant_sum = {1'b0, mant_raw} + {{MW{1'b0}}, round_up};
    // Carry-out leaves the low mantissa bits at zero; bump the exponent instead.
    exp_rnd  = mant_sum[MW] ? (exp_q + ExpOne) : exp_q;
  end

  // Datapath next-state.
  always_comb begin
    mag_d     = mag_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    zero_d    = zero_q;
    wen_d     = 1'b0;
    wdata_d   = wdata_q;
    inexact_d = inexact_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          sign_d = int_i[IntWidth-1];
          // The most negative value negates onto itself, which is the correct magnitude.
          mag_d  = int_i[IntWidth-1] ? (~int_i + IntOne) : int_i;
          exp_d  = ExpInit;
          zero_d = 1'b0;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          zero_d = 1'b1;
        end else if (!mag_q[IntWidth-1]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - ExpOne;
        end
      end
      PACK: begin
        wen_d     = 1'b1;
        inexact_d = guard | sticky;
        if (zero_q) begin
          wdata_d = '0;
        end else begin
          wdata_d.sign     = sign_q;
          wdata_d.exponent = exp_rnd;
          wdata_d.mantissa = mant_sum[MW-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mag_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      inexact_q <= 1'b0;
    end else begin
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      zero_q    <= zero_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      inexact_q <= inexact_d;
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Directed-vector bench for int_to_float with a queue-based scoreboard.
// Latency: each expectation carries the cycle its strobe is due.
// Backpressure: the driver waits on ready_o before every accept.
module tb_int_to_float;

  logic                 clk_i;
  logic                 rst_i;
  logic                 valid_i;
  logic [31:0]          int_i;
  logic                 ready_o;
  logic                 wen_o;
  float_pkg::float_t    wdata_o;
  logic                 inexact_o;

  int_to_float #(.IntWidth(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .int_i     (int_i),
    .ready_o   (ready_o),
    .wen_o     (wen_o),
    .wdata_o   (wdata_o),
    .inexact_o (inexact_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        inex;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_wen = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per observed strobe.
  always @(negedge clk_i) begin
    exp_t e;
    if (wen_o === 1'b1) begin
      chk("wen_single_cycle", {31'd0, prev_wen}, 32'd0);
      chk("ready_with_wen", {31'd0, ready_o}, 32'd1);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wen: got data 0x%08h at cycle %0d expected no strobe", wdata_o, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("wdata", wdata_o, e.data);
        chk("inexact", {31'd0, inexact_o}, {31'd0, e.inex});
        chk("latency", cyc, e.due);
      end
    end
    prev_wen = wen_o;
  end

  // Drive one operand with valid_i left high; accept happens on the first edge seen with ready_o.
  task automatic send(input logic [31:0] v, input logic [31:0] ed, input logic ei,
                      input int lz, input bit push);
    int   n;
    exp_t e;
    valid_i = 1'b1;
    int_i   = v;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout: got ready_o=0 for 200 cycles expected 1");
        break;
      end
    end
    @(posedge clk_i);
    #1;
    if (push) begin
      e.data = ed;
      e.inex = ei;
      e.due  = cyc + 2 + lz;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
    end
  endtask

  logic [31:0] exp_max, exp_rt;

  initial begin
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
    exp_max = 32'h4F00_0000;
    exp_rt  = 32'h4B80_0002;
`else
    exp_max = 32'h4EFF_FFFF;
    exp_rt  = 32'h4B80_0001;
`endif
    rst_i   = 1'b1;
    valid_i = 1'b0;
    int_i   = '0;
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_wen", {31'd0, wen_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_inexact", {31'd0, inexact_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Single conversions with idle gaps.
    send(32'd1,        32'h3F80_0000, 1'b0, 31, 1'b1); valid_i = 1'b0; drain();
    send(32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 31, 1'b1); valid_i = 1'b0; drain();
    send(32'd0,        32'h0000_0000, 1'b0, 0,  1'b1); valid_i = 1'b0; drain();
    send(32'h8000_0000, 32'hCF00_0000, 1'b0, 0,  1'b1); valid_i = 1'b0; drain();
    send(32'h7FFF_FFFF, exp_max,       1'b1, 1,  1'b1); valid_i = 1'b0; drain();
    send(32'd16777217, 32'h4B80_0000, 1'b1, 7,  1'b1); valid_i = 1'b0; drain();
    send(32'd16777219, exp_rt,        1'b1, 7,  1'b1); valid_i = 1'b0; drain();

    // valid_i held across three operands: each accept lands on the previous strobe cycle.
    send(32'd3,         32'h4040_0000, 1'b0, 30, 1'b1);
    send(32'hFFFF_FFF9, 32'hC0E0_0000, 1'b0, 29, 1'b1);
    send(32'd100,       32'h42C8_0000, 1'b0, 25, 1'b1);
    valid_i = 1'b0;
    drain();

    // Reset while normalising: the in-flight result must never appear.
    send(32'd1, 32'h0, 1'b0, 31, 1'b0);
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("busy_ready", {31'd0, ready_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    chk("midrst_wen", {31'd0, wen_o}, 32'd0);
    chk("midrst_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    chk("postrst_wdata", wdata_o, 32'd0);
    send(32'd5, 32'h40A0_0000, 1'b0, 29, 1'b1);
    valid_i = 1'b0;
    drain();
    repeat (3) @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
